// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one single-port ROM among NREQ readers,
// port 0 (pixel fetch) pre-empts during active video, round-robin otherwise.
//
// Ports:
//   vga_clk, rst_n       clock, async active-low reset
//   blank                high = active pixel region (port 0 priority)
//   req_valid/req_addr   per-port read requests (port i at [i*ADDR_W +: ADDR_W])
//   req_ready            one-hot combinational grant
//   rom_addr/rom_q       registered ROM address, ROM read data
//   rsp_valid/rsp_data   registered one-hot owner tag and read data
//   starve_cnt           saturating count of cycles a port >= 1 waited
module sprite_rom_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                     vga_clk,
    input  logic                     rst_n,
    input  logic                     blank,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    output logic [NREQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_q,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [15:0]              starve_cnt
);

    localparam int RR_W = $clog2(NREQ);

    logic [RR_W-1:0]   rr;
    logic [RR_W-1:0]   win;
    logic [NREQ-1:0]   grant;
    logic              prio;
    logic              accept;
    logic              waiting;
    logic [ADDR_W-1:0] sel_addr;
    logic [NREQ-1:0]   tag [ROM_LAT];
    logic [NREQ-1:0]   tag_out;

    // Grant: port 0 pre-empts while blank is high; otherwise search
    // upward from rr, skipping port 0 when blank is high.
    always_comb begin
        int idx;
        grant = '0;
        win   = '0;
        prio  = 1'b0;
        idx   = 0;
        if (rst_n) begin
            if (blank && req_valid[0]) begin
                grant[0] = 1'b1;
                prio     = 1'b1;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (int'(rr) + k) % NREQ;
                    if (grant == '0 && req_valid[idx] &&
                        !(blank && idx == 0)) begin
                        grant[idx] = 1'b1;
                        win        = RR_W'(idx);
                    end
                end
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign tag_out   = tag[ROM_LAT-1];

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // A cycle counts as starving if any non-pixel port is left waiting.
    assign waiting = |(req_valid[NREQ-1:1] & ~grant[NREQ-1:1]);

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rr         <= '0;
            rom_addr   <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            starve_cnt <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                tag[i] <= '0;
            end
        end else begin
            if (accept) begin
                rom_addr <= sel_addr;
            end
            if (accept && !prio) begin
                rr <= (win == RR_W'(NREQ-1)) ? '0 : win + 1'b1;
            end
            tag[0] <= grant;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag[i] <= tag[i-1];
            end
            rsp_valid <= tag_out;
            if (|tag_out) begin
                rsp_data <= rom_q;
            end
            if (waiting && starve_cnt != 16'hFFFF) begin
                starve_cnt <= starve_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: grant table, single read, reset discard,
// priority mode, ROM_LAT=2 pipelining and starve counter saturation.
module tb_sprite_rom_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 15;
    localparam int DW   = 8;

    logic              vga_clk = 1'b0;
    logic              rst_n;
    logic              blank;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;

    logic [NREQ-1:0] ready1, ready2;
    logic [AW-1:0]   rom_addr1, rom_addr2;
    logic [DW-1:0]   rom_q1, rom_q2;
    logic [NREQ-1:0] rsp_valid1, rsp_valid2;
    logic [DW-1:0]   rsp_data1, rsp_data2;
    logic [15:0]     starve1, starve2;

    int tests = 0;
    int fails = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW),
                         .ROM_LAT(1)) dut1 (
        .vga_clk(vga_clk), .rst_n(rst_n), .blank(blank),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready1), .rom_addr(rom_addr1), .rom_q(rom_q1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .starve_cnt(starve1)
    );

    sprite_rom_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW),
                         .ROM_LAT(2)) dut2 (
        .vga_clk(vga_clk), .rst_n(rst_n), .blank(blank),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready2), .rom_addr(rom_addr2), .rom_q(rom_q2),
        .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
        .starve_cnt(starve2)
    );

    // ROM models: data = addr[7:0]; latency 1 is combinational from
    // rom_addr, latency 2 adds one register stage.
    assign rom_q1 = rom_addr1[7:0];
    always @(posedge vga_clk) rom_q2 <= rom_addr2[7:0];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    typedef struct {
        logic       blank;
        logic [3:0] valid;
        logic [3:0] ready;
    } vec_t;

    vec_t vt [21];
    logic [AW-1:0] atab [4];

    function automatic logic [AW-1:0] addr_of(input logic [3:0] oh);
        logic [AW-1:0] a;
        a = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) a = atab[i];
        end
        return a;
    endfunction

    initial begin
        logic [3:0]    p1, p2;
        logic [AW-1:0] exp_rom;

        atab[0] = 15'h0011;
        atab[1] = 15'h0122;
        atab[2] = 15'h0233;
        atab[3] = 15'h7344;

        // Grant sequence from reset (rr=0), expected by hand.
        vt[0]  = '{1'b0, 4'b1111, 4'b0001};
        vt[1]  = '{1'b0, 4'b1111, 4'b0010};
        vt[2]  = '{1'b0, 4'b1111, 4'b0100};
        vt[3]  = '{1'b0, 4'b1111, 4'b1000};
        vt[4]  = '{1'b0, 4'b1111, 4'b0001};
        vt[5]  = '{1'b0, 4'b1111, 4'b0010};
        vt[6]  = '{1'b0, 4'b1111, 4'b0100};
        vt[7]  = '{1'b0, 4'b1111, 4'b1000};
        vt[8]  = '{1'b1, 4'b1001, 4'b0001};
        vt[9]  = '{1'b1, 4'b1001, 4'b0001};
        vt[10] = '{1'b1, 4'b1001, 4'b0001};
        vt[11] = '{1'b1, 4'b1001, 4'b0001};
        vt[12] = '{1'b1, 4'b1001, 4'b0001};
        vt[13] = '{1'b0, 4'b1000, 4'b1000};
        vt[14] = '{1'b0, 4'b1001, 4'b0001};
        vt[15] = '{1'b1, 4'b0110, 4'b0010};
        vt[16] = '{1'b0, 4'b0000, 4'b0000};
        vt[17] = '{1'b0, 4'b0011, 4'b0001};
        vt[18] = '{1'b1, 4'b1110, 4'b0010};
        vt[19] = '{1'b1, 4'b1011, 4'b0001};
        vt[20] = '{1'b0, 4'b1011, 4'b1000};

        // Reset state
        rst_n     = 1'b0;
        blank     = 1'b0;
        req_valid = 4'b1111;
        req_addr  = '0;
        for (int i = 0; i < 4; i++) set_addr(i, atab[i]);
        repeat (2) step();
        chk("rst_ready", ready1, 4'b0000);
        chk("rst_rom_addr", rom_addr1, 15'h0);
        chk("rst_rsp_valid", rsp_valid1, 4'b0000);
        chk("rst_rsp_data", rsp_data1, 8'h00);
        chk("rst_starve", starve1, 16'h0);
        rst_n = 1'b1;

        // Table-driven grant / rom_addr / response checks
        p1 = '0;
        p2 = '0;
        exp_rom = '0;
        for (int j = 0; j < 21; j++) begin
            blank     = vt[j].blank;
            req_valid = vt[j].valid;
            @(negedge vga_clk);
            chk($sformatf("tbl%0d_ready", j), ready1, vt[j].ready);
            chk($sformatf("tbl%0d_ready_l2", j), ready2, vt[j].ready);
            chk($sformatf("tbl%0d_rom_addr", j), rom_addr1, exp_rom);
            chk($sformatf("tbl%0d_rsp_valid", j), rsp_valid1, p2);
            if (p2 != 4'b0000)
                chk($sformatf("tbl%0d_rsp_data", j), rsp_data1,
                    {24'h0, addr_of(p2)[7:0]});
            p2 = p1;
            p1 = vt[j].ready;
            if (vt[j].ready != 4'b0000) exp_rom = addr_of(vt[j].ready);
            step();
        end
        req_valid = 4'b0000;
        repeat (3) step();

        // Single read: port 2, addr 15'h1234
        blank = 1'b0;
        set_addr(2, 15'h1234);
        req_valid = 4'b0100;
        @(negedge vga_clk);
        chk("single_ready", ready1, 4'b0100);
        step();
        req_valid = 4'b0000;
        @(negedge vga_clk);
        chk("single_rom_addr", rom_addr1, 15'h1234);
        chk("single_rsp_early", rsp_valid1, 4'b0000);
        step();
        @(negedge vga_clk);
        chk("single_rsp_valid", rsp_valid1, 4'b0100);
        chk("single_rsp_data", rsp_data1, 8'h34);
        step();
        @(negedge vga_clk);
        chk("single_rsp_once", rsp_valid1, 4'b0000);

        // Mid-stream reset with one read in flight
        step();
        set_addr(1, 15'h0055);
        req_valid = 4'b0010;
        @(negedge vga_clk);
        chk("inflight_ready", ready1, 4'b0010);
        step();
        req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", ready1, 4'b0000);
        chk("arst_rom_addr", rom_addr1, 15'h0);
        chk("arst_rsp_valid", rsp_valid1, 4'b0000);
        chk("arst_rsp_data", rsp_data1, 8'h00);
        chk("arst_starve", starve1, 16'h0);
        chk("arst_rsp_valid_l2", rsp_valid2, 4'b0000);
        step();
        req_valid = 4'b0000;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge vga_clk);
            chk($sformatf("discard%0d_rsp", c), rsp_valid1, 4'b0000);
            chk($sformatf("discard%0d_rsp_l2", c), rsp_valid2, 4'b0000);
            step();
        end

        // Priority mode from rr=0, starve_cnt=0 after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        blank = 1'b1;
        req_valid = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            @(negedge vga_clk);
            chk($sformatf("prio%0d_ready", c), ready1, 4'b0001);
            step();
        end
        chk("prio_starve", starve1, 16'd5);
        blank = 1'b0;
        @(negedge vga_clk);
        chk("prio_rr_kept", ready1, 4'b0001);
        step();
        req_valid = 4'b1000;
        @(negedge vga_clk);
        chk("prio_p3_after", ready1, 4'b1000);
        step();
        req_valid = 4'b0000;
        repeat (4) step();

        // ROM_LAT=2 pipelining: ports 1,2,1 with addrs 10,20,30
        set_addr(1, 15'd10);
        req_valid = 4'b0010;
        @(negedge vga_clk);
        chk("pipe_ready_a", ready2, 4'b0010);
        step();
        set_addr(2, 15'd20);
        req_valid = 4'b0100;
        @(negedge vga_clk);
        chk("pipe_ready_b", ready2, 4'b0100);
        chk("pipe_rsp_k", rsp_valid2, 4'b0000);
        step();
        set_addr(1, 15'd30);
        req_valid = 4'b0010;
        @(negedge vga_clk);
        chk("pipe_ready_c", ready2, 4'b0010);
        chk("pipe_rsp_k1", rsp_valid2, 4'b0000);
        step();
        req_valid = 4'b0000;
        @(negedge vga_clk);
        chk("pipe_rsp1_valid", rsp_valid2, 4'b0010);
        chk("pipe_rsp1_data", rsp_data2, 8'd10);
        step();
        @(negedge vga_clk);
        chk("pipe_rsp2_valid", rsp_valid2, 4'b0100);
        chk("pipe_rsp2_data", rsp_data2, 8'd20);
        step();
        @(negedge vga_clk);
        chk("pipe_rsp3_valid", rsp_valid2, 4'b0010);
        chk("pipe_rsp3_data", rsp_data2, 8'd30);
        step();
        @(negedge vga_clk);
        chk("pipe_rsp_end", rsp_valid2, 4'b0000);

        // Saturation: port 1 starved behind port 0 in active video
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        blank = 1'b1;
        req_valid = 4'b0011;
        repeat (100) step();
        chk("starve_100", starve1, 16'd100);
        repeat (69900) step();
        chk("starve_sat", starve1, 16'hFFFF);
        repeat (5) step();
        chk("starve_hold", starve1, 16'hFFFF);
        chk("starve_hold_l2", starve2, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
